flsh_cfg_initiator: RTL and testbench
=====================================

Name: flsh_cfg_initiator

Overview:
Requester for the flash subsystem's held-strobe config port (cfg_flsh_*/flsh_cfg_*). It accepts single read/write commands from the host-side MMIO decoder over a valid/ready handshake. Each command is driven onto the flash port with strobes held stable until done, and the result is returned as a one-cycle response. It adds a timeout watchdog and sticky protocol-error flags, and sits between the host config register block and the flash subsystem in the clock_tlx domain.

Parameters:
TIMEOUT_CYCLES, 4096, max cycles wren/rden held without flsh_cfg_done before abort (≥2)
TO_W, 13, timeout counter width (must hold TIMEOUT_CYCLES)

Ports:
clock  input  1  clock_tlx domain clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  command present
req_ready  output  1  command accepted when valid&ready
req_write  input  1  1=write, 0=read
req_devsel  input  2  target AXI4-Lite slave
req_addr  input  14  target address
req_wdata  input  32  write data
req_expand_enable  input  1  byte expand/collapse enable
req_expand_dir  input  1  expand order
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  read data (0 for writes/timeouts)
rsp_resp  output  2  bresp or rresp; 2'b10 on timeout
rsp_timeout  output  1  qualifies rsp_valid: command aborted
cfg_flsh_devsel/addr/wdata/expand_enable/expand_dir  output  2/14/32/1/1  registered command fields
cfg_flsh_wren  output  1  write strobe, held until done
cfg_flsh_rden  output  1  read strobe, held until done
flsh_cfg_rdata  input  32  read data from flash subsystem
flsh_cfg_done  input  1  completion pulse
flsh_cfg_bresp  input  2  write response
flsh_cfg_rresp  input  2  read response
err_clear  input  1  clears sticky errors
err_unexpected_done  output  1  sticky: done seen while no strobe held
err_timeout  output  1  sticky: any timeout occurred
busy  output  1  state != IDLE

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0 except req_ready=1. An in-flight command is dropped, strobes fall asynchronously, and no response is produced.
- States: IDLE, ISSUE, RESP, GAP.
- IDLE: req_ready=1. On valid&ready, register all req_* fields into cfg_flsh_* and clear the timeout counter; next state is ISSUE.
- ISSUE: exactly one of wren/rden=1, per registered req_write; fields stable; counter increments each cycle.
  - flsh_cfg_done=1: capture rdata (read) or 0 (write), and resp = rresp (read) or bresp (write); rsp_timeout=0. Next state is RESP.
  - Counter reaches TIMEOUT_CYCLES-1 without done: capture rdata=0, resp=2'b10, rsp_timeout=1; set err_timeout. Next state is RESP.
  - done takes priority over timeout in the same cycle.
- RESP: strobes=0; rsp_valid=1 for this single cycle with captured data. Next state is GAP.
- GAP: strobes=0; one idle cycle guaranteeing strobe low before the next command. Next state is IDLE.
- Latency: accept at T → strobe high at T+1 → done at T+1+k (k≥0) → rsp_valid at T+2+k → req_ready at T+4+k. Back-to-back throughput is one command per k+4 cycles.
- rsp_* hold their values outside the rsp_valid cycle; consumers sample only on rsp_valid.
- flsh_cfg_done in IDLE, RESP or GAP (spurious or late after timeout): ignored for data and sets err_unexpected_done.
- err_clear clears both sticky flags. If a set event and err_clear coincide, set wins.
- req_* fields are don't-care when req_valid=0. No combinational path from req_valid to req_ready.

Decomposition:
- Shared package flsh_cfg_pkg: state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2, GAP=2'd3), AXI resp constants (OKAY=2'b00, SLVERR=2'b10), devsel constants.
- No sub-module. The timeout counter is inline.

Test Plan:
- Read, done after k=5, rresp=00, rdata=32'hDEADBEEF, devsel=1, addr=14'h0123 → rden high 6 cycles with fields stable, wren=0; rsp_valid at T+7 with rdata=DEADBEEF, resp=00, timeout=0; ready at T+9.
- Write with wdata=32'hA5A5_0001, done after k=0, bresp=10 → wren high 1 cycle; rsp_resp=10, rsp_rdata=0.
- Read with no done, TIMEOUT_CYCLES=16 → rden high exactly 16 cycles; rsp_valid with resp=10 and timeout=1; err_timeout=1. A late done 3 cycles later sets err_unexpected_done with no second rsp_valid.
- req_valid held continuously for 3 commands, k=2 → commands accepted every 6 cycles; strobe low ≥2 cycles between commands; 3 responses in order.
- Reset asserted mid-ISSUE → strobes and rsp_valid 0 immediately, req_ready=1 after reset; done arriving afterwards sets err_unexpected_done.
- err_clear and a spurious done in the same cycle → err_unexpected_done remains 1. err_clear alone on the next cycle → 0.

Source files
------------

// File: rtl/flsh_cfg_pkg.sv
// flsh_cfg_pkg: shared encodings for the flash config-port requester.
package flsh_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic [1:0] DEVSEL_0 = 2'd0;
    localparam logic [1:0] DEVSEL_1 = 2'd1;
    localparam logic [1:0] DEVSEL_2 = 2'd2;
    localparam logic [1:0] DEVSEL_3 = 2'd3;

endpackage

// File: rtl/flsh_cfg_initiator.sv
// flsh_cfg_initiator: drives one held-strobe flash config access per command,
// with a timeout watchdog and sticky protocol-error flags.
module flsh_cfg_initiator
    import flsh_cfg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_devsel,
    input  logic [13:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_expand_enable,
    input  logic        req_expand_dir,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic [1:0]  cfg_flsh_devsel,
    output logic [13:0] cfg_flsh_addr,
    output logic [31:0] cfg_flsh_wdata,
    output logic        cfg_flsh_expand_enable,
    output logic        cfg_flsh_expand_dir,
    output logic        cfg_flsh_wren,
    output logic        cfg_flsh_rden,
    input  logic [31:0] flsh_cfg_rdata,
    input  logic        flsh_cfg_done,
    input  logic [1:0]  flsh_cfg_bresp,
    input  logic [1:0]  flsh_cfg_rresp,
    input  logic        err_clear,
    output logic        err_unexpected_done,
    output logic        err_timeout,
    output logic        busy
);

    state_t          state, state_nxt;
    logic            write_q;
    logic [TO_W-1:0] cnt;
    logic            accept, timeout_hit, done_hit;

    assign accept      = req_valid && req_ready;
    assign done_hit    = (state == ISSUE) && flsh_cfg_done;
    // done wins over an expiring counter in the same cycle
    assign timeout_hit = (state == ISSUE) && !flsh_cfg_done && (cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = req_valid ? ISSUE : IDLE;
            ISSUE:   state_nxt = (done_hit || timeout_hit) ? RESP : ISSUE;
            RESP:    state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = (state == IDLE);
        busy          = (state != IDLE);
        rsp_valid     = (state == RESP);
        cfg_flsh_wren = (state == ISSUE) && write_q;
        cfg_flsh_rden = (state == ISSUE) && !write_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_q                <= 1'b0;
            cfg_flsh_devsel        <= '0;
            cfg_flsh_addr          <= '0;
            cfg_flsh_wdata         <= '0;
            cfg_flsh_expand_enable <= 1'b0;
            cfg_flsh_expand_dir    <= 1'b0;
            cnt                    <= '0;
        end else if (accept) begin
            write_q                <= req_write;
            cfg_flsh_devsel        <= req_devsel;
            cfg_flsh_addr          <= req_addr;
            cfg_flsh_wdata         <= req_wdata;
            cfg_flsh_expand_enable <= req_expand_enable;
            cfg_flsh_expand_dir    <= req_expand_dir;
            cnt                    <= '0;
        end else if (state == ISSUE) begin
            cnt <= cnt + 1'b1;
        end
    end

    // response fields hold between pulses; consumers qualify with rsp_valid
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_rdata   <= '0;
            rsp_resp    <= OKAY;
            rsp_timeout <= 1'b0;
        end else if (done_hit) begin
            rsp_rdata   <= write_q ? 32'h0 : flsh_cfg_rdata;
            rsp_resp    <= write_q ? flsh_cfg_bresp : flsh_cfg_rresp;
            rsp_timeout <= 1'b0;
        end else if (timeout_hit) begin
            rsp_rdata   <= 32'h0;
            rsp_resp    <= SLVERR;
            rsp_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_unexpected_done <= 1'b0;
            err_timeout         <= 1'b0;
        end else begin
            err_unexpected_done <= (flsh_cfg_done && state != ISSUE) || (err_unexpected_done && !err_clear);
            err_timeout         <= timeout_hit || (err_timeout && !err_clear);
        end
    end

endmodule

// File: tb/tb_flsh_cfg_initiator.sv
// tb_flsh_cfg_initiator: directed and randomized commands checked against a
// transaction-level model of the held-strobe flash config protocol.
module tb_flsh_cfg_initiator;
    import flsh_cfg_pkg::*;

    localparam int TO = 16;

    logic        clock = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [1:0]  req_devsel = '0;
    logic [13:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_expand_enable = 1'b0, req_expand_dir = 1'b0;
    logic        rsp_valid, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [1:0]  cfg_flsh_devsel;
    logic [13:0] cfg_flsh_addr;
    logic [31:0] cfg_flsh_wdata;
    logic        cfg_flsh_expand_enable, cfg_flsh_expand_dir, cfg_flsh_wren, cfg_flsh_rden;
    logic [31:0] flsh_cfg_rdata = '0;
    logic        flsh_cfg_done = 1'b0;
    logic [1:0]  flsh_cfg_bresp = '0, flsh_cfg_rresp = '0;
    logic        err_clear = 1'b0, err_unexpected_done, err_timeout, busy;

    int   n_cmp = 0, n_err = 0, cyc = 0;
    logic exp_ud = 1'b0, exp_to = 1'b0;
    int   acc0, acc1, acc2;

    flsh_cfg_initiator #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_devsel(req_devsel), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_expand_enable(req_expand_enable), .req_expand_dir(req_expand_dir),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .cfg_flsh_devsel(cfg_flsh_devsel), .cfg_flsh_addr(cfg_flsh_addr), .cfg_flsh_wdata(cfg_flsh_wdata),
        .cfg_flsh_expand_enable(cfg_flsh_expand_enable), .cfg_flsh_expand_dir(cfg_flsh_expand_dir),
        .cfg_flsh_wren(cfg_flsh_wren), .cfg_flsh_rden(cfg_flsh_rden),
        .flsh_cfg_rdata(flsh_cfg_rdata), .flsh_cfg_done(flsh_cfg_done),
        .flsh_cfg_bresp(flsh_cfg_bresp), .flsh_cfg_rresp(flsh_cfg_rresp),
        .err_clear(err_clear), .err_unexpected_done(err_unexpected_done),
        .err_timeout(err_timeout), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // One command end to end; k < 0 means the flash side never answers.
    task automatic run_cmd(input logic wr, input logic [1:0] ds, input logic [13:0] ad,
                           input logic [31:0] wd, input logic ee, input logic ed,
                           input int k, input logic [1:0] rs, input logic [31:0] rd,
                           input bit keep, output int acc);
        int          hold;
        logic        to;
        logic [31:0] e_rd;
        logic [1:0]  e_rs;
        to   = (k < 0);
        hold = to ? TO : k + 1;
        e_rd = (wr || to) ? 32'h0 : rd;
        e_rs = to ? SLVERR : rs;
        @(negedge clock);
        chk("ready_idle", req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_devsel = ds; req_addr = ad;
        req_wdata = wd; req_expand_enable = ee; req_expand_dir = ed;
        acc = cyc;
        @(negedge clock);
        if (!keep) begin
            req_valid = 1'b0; req_write = ~wr; req_devsel = 2'($urandom);
            req_addr = 14'($urandom); req_wdata = $urandom;
            req_expand_enable = ~ee; req_expand_dir = ~ed;
        end
        for (int i = 0; i < hold; i++) begin
            chk("wren", cfg_flsh_wren, wr);
            chk("rden", cfg_flsh_rden, !wr);
            chk("devsel", cfg_flsh_devsel, ds);
            chk("addr", cfg_flsh_addr, ad);
            chk("wdata", cfg_flsh_wdata, wd);
            chk("exp_en", cfg_flsh_expand_enable, ee);
            chk("exp_dir", cfg_flsh_expand_dir, ed);
            chk("ready_issue", req_ready, 0);
            chk("rsp_quiet", rsp_valid, 0);
            flsh_cfg_done  = (i == k);
            flsh_cfg_rdata = (i == k) ? rd : $urandom;
            flsh_cfg_bresp = wr ? rs : 2'($urandom);
            flsh_cfg_rresp = wr ? 2'($urandom) : rs;
            @(negedge clock);
        end
        flsh_cfg_done = 1'b0;
        if (to) exp_to = 1'b1;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_rdata", rsp_rdata, e_rd);
        chk("rsp_resp", rsp_resp, e_rs);
        chk("rsp_timeout", rsp_timeout, to);
        chk("wren_resp", cfg_flsh_wren, 0);
        chk("rden_resp", cfg_flsh_rden, 0);
        chk("err_timeout", err_timeout, exp_to);
        chk("err_ud", err_unexpected_done, exp_ud);
        @(negedge clock);
        chk("rsp_gap", rsp_valid, 0);
        chk("ready_gap", req_ready, 0);
        chk("busy_gap", busy, 1);
        chk("strobe_gap", cfg_flsh_wren | cfg_flsh_rden, 0);
        chk("rdata_hold", rsp_rdata, e_rd);
    endtask

    initial begin
        #12;
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_strobes", cfg_flsh_wren | cfg_flsh_rden, 0);
        chk("rst_addr", cfg_flsh_addr, 0);
        chk("rst_errs", err_unexpected_done | err_timeout, 0);
        @(negedge clock);
        reset = 1'b0;

        // read, k=5
        run_cmd(1'b0, 2'd1, 14'h0123, 32'h0, 1'b1, 1'b0, 5, OKAY, 32'hDEADBEEF, 1'b0, acc0);
        // write, k=0, SLVERR
        run_cmd(1'b1, 2'd2, 14'h3ABC, 32'hA5A5_0001, 1'b0, 1'b1, 0, SLVERR, 32'h1234_5678, 1'b0, acc0);
        // read that never completes
        run_cmd(1'b0, 2'd3, 14'h0042, 32'h0, 1'b0, 1'b0, -1, OKAY, 32'hFFFF_FFFF, 1'b0, acc0);
        @(negedge clock);
        @(negedge clock);
        flsh_cfg_done = 1'b1;
        @(negedge clock);
        flsh_cfg_done = 1'b0;
        exp_ud = 1'b1;
        chk("late_done_ud", err_unexpected_done, 1);
        chk("late_done_norsp", rsp_valid, 0);
        chk("late_done_idle", busy, 0);
        @(negedge clock);
        chk("late_done_norsp2", rsp_valid, 0);

        // back-to-back with valid held, k=2
        run_cmd(1'b0, 2'd0, 14'h0001, 32'h0, 1'b0, 1'b0, 2, 2'b01, 32'h0000_1111, 1'b1, acc0);
        run_cmd(1'b1, 2'd1, 14'h0002, 32'h2222_0000, 1'b1, 1'b1, 2, OKAY, 32'h0, 1'b1, acc1);
        run_cmd(1'b0, 2'd2, 14'h0003, 32'h0, 1'b0, 1'b1, 2, 2'b11, 32'h3333_3333, 1'b1, acc2);
        req_valid = 1'b0;
        chk("b2b_gap1", acc1 - acc0, 6);
        chk("b2b_gap2", acc2 - acc1, 6);

        // reset mid-ISSUE
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 14'h0777;
        @(negedge clock);
        req_valid = 1'b0;
        chk("pre_rst_rden", cfg_flsh_rden, 1);
        #2 reset = 1'b1;
        #1;
        exp_ud = 1'b0; exp_to = 1'b0;
        chk("async_rden", cfg_flsh_rden, 0);
        chk("async_wren", cfg_flsh_wren, 0);
        chk("async_rsp", rsp_valid, 0);
        chk("async_ready", req_ready, 1);
        chk("async_errs", err_unexpected_done | err_timeout, 0);
        @(negedge clock);
        reset = 1'b0;
        flsh_cfg_done = 1'b1;
        @(negedge clock);
        flsh_cfg_done = 1'b0;
        exp_ud = 1'b1;
        chk("post_rst_ud", err_unexpected_done, 1);
        chk("post_rst_norsp", rsp_valid, 0);

        // clear vs. set collision: set wins
        flsh_cfg_done = 1'b1; err_clear = 1'b1;
        @(negedge clock);
        chk("clr_set_wins", err_unexpected_done, 1);
        flsh_cfg_done = 1'b0;
        @(negedge clock);
        err_clear = 1'b0;
        exp_ud = 1'b0;
        chk("clr_alone", err_unexpected_done, 0);

        // randomized commands
        for (int n = 0; n < 24; n++) begin
            int k;
            k = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
            run_cmd(1'($urandom), 2'($urandom), 14'($urandom), $urandom, 1'($urandom),
                    1'($urandom), k, 2'($urandom), $urandom, 1'($urandom), acc0);
        end
        req_valid = 1'b0;
        @(negedge clock);
        err_clear = 1'b1;
        @(negedge clock);
        err_clear = 1'b0;
        exp_to = 1'b0;
        chk("final_clr_to", err_timeout, 0);
        chk("final_clr_ud", err_unexpected_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
